shift_arbiter: RTL and testbench

- Shares the single 16-bit combinational shifter datapath (fcode 4'b1000 SLL, 4'b1001 SLR, 4'b1010 SRL, 4'b1011 SRA) between two requesters, e.g. execute stage and address unit.
- Arbitrates and registers the shifter operands, captures the result, and computes the {s,z,c,v} condition code. The shifter does not drive that code.
- Corrects results for shift amounts of 16 or more, which the shifter does not handle.

---
 rtl/shift_arbiter.sv | 139 +++++++++++++
 tb/tb_shift_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-requester front end for the shared 16-bit combinational shifter: arbitrates, registers operands,
// fixes up shift amounts >= 16 and computes {s,z,c,v}. Define SHIFT_ARB_FIXED_PRIO_EN for fixed req0 priority.
module shift_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [3:0]   fcode0,
  input  logic [4:0]   shamt0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [3:0]   fcode1,
  input  logic [4:0]   shamt1,
  input  logic [W-1:0] data1,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic [W-1:0] result,
  output logic [3:0]   code,
  output logic [3:0]   sh_fcode,
  output logic [4:0]   sh_shift,
  output logic [W-1:0] sh_in,
  input  logic [W-1:0] sh_result
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t       state;
  logic [3:0]   op_fcode;
  logic [4:0]   op_shamt;
  logic [W-1:0] op_data;
  logic         op_id;
  logic         pick;

  // pick = 1 selects requester 1
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign pick = !req0;
`else
  logic rr;
  assign pick = (req0 && req1) ? rr : !req0;
`endif

  logic [3:0]   sel_fcode;
  logic [4:0]   sel_shamt;
  logic [W-1:0] sel_data;

  always_comb begin
    sel_fcode = pick ? fcode1 : fcode0;
    sel_shamt = pick ? shamt1 : shamt0;
    sel_data  = pick ? data1  : data0;
  end

  logic         legal, is_slr, is_sra;
  logic [W-1:0] nres;
  logic         nc;
  logic [3:0]   ncode;
  logic [3:0]   idx_l, idx_r;

  // Carry is the last bit shifted out; the shifter only sees shamt[3:0], so n >= 16 is patched here.
  always_comb begin
    legal  = (op_fcode[3:2] == 2'b10);
    is_slr = (op_fcode[1:0] == 2'b01);
    is_sra = (op_fcode[1:0] == 2'b11);
    idx_l  = 4'(5'd16 - op_shamt);
    idx_r  = 4'(op_shamt - 5'd1);
    nres   = op_data;
    nc     = 1'b0;
    ncode  = {op_data[W-1], (op_data == '0), 1'b0, 1'b1};
    if (legal) begin
      if (op_shamt < 5'd16 || is_slr) nres = sh_result;
      else if (is_sra)                nres = {W{op_data[W-1]}};
      else                            nres = '0;
      case (op_fcode[1:0])
        2'b00:   nc = (op_shamt != 5'd0 && op_shamt <= 5'd16) ? op_data[idx_l] : 1'b0;
        2'b01:   nc = (op_shamt[3:0] != 4'd0) ? nres[0] : 1'b0;
        2'b10:   nc = (op_shamt != 5'd0 && op_shamt <= 5'd16) ? op_data[idx_r] : 1'b0;
        default: nc = (op_shamt == 5'd0) ? 1'b0 :
                      (op_shamt <= 5'd16) ? op_data[idx_r] : op_data[W-1];
      endcase
      ncode = {nres[W-1], (nres == '0), nc, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      code     <= '0;
      sh_fcode <= 4'b1000;
      sh_shift <= '0;
      sh_in    <= '0;
      op_fcode <= '0;
      op_shamt <= '0;
      op_data  <= '0;
      op_id    <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      rr       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_id    <= pick;
            op_fcode <= sel_fcode;
            op_shamt <= sel_shamt;
            op_data  <= sel_data;
            sh_fcode <= sel_fcode;
            sh_shift <= {1'b0, sel_shamt[3:0]};
            sh_in    <= sel_data;
            busy     <= 1'b1;
            state    <= DRIVE;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr       <= ~pick;
`endif
          end
        end
        DRIVE: begin
          result <= nres;
          code   <= ncode;
          done0  <= !op_id;
          done1  <= op_id;
          state  <= RESP;
        end
        RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: behavioural shifter, directed table, arbitration/reset sequences and
// randomized ops checked against an arithmetic reference model.
module tb_shift_arbiter;

  logic        clk, rst;
  logic        req0, req1;
  logic [3:0]  fcode0, fcode1;
  logic [4:0]  shamt0, shamt1;
  logic [15:0] data0, data1;
  logic        done0, done1, busy;
  logic [15:0] result;
  logic [3:0]  code;
  logic [3:0]  sh_fcode;
  logic [4:0]  sh_shift;
  logic [15:0] sh_in;
  logic [15:0] sh_result;

  int vectors = 0;
  int miscompares = 0;

  shift_arbiter #(.W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .fcode0(fcode0), .shamt0(shamt0), .data0(data0),
    .req1(req1), .fcode1(fcode1), .shamt1(shamt1), .data1(data1),
    .done0(done0), .done1(done1), .busy(busy),
    .result(result), .code(code),
    .sh_fcode(sh_fcode), .sh_shift(sh_shift), .sh_in(sh_in),
    .sh_result(sh_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shifter: only looks at shift[3:0]
  logic [31:0] rot;
  always_comb begin
    rot = {sh_in, sh_in} << sh_shift[3:0];
    case (sh_fcode)
      4'b1000: sh_result = sh_in << sh_shift[3:0];
      4'b1001: sh_result = rot[31:16];
      4'b1010: sh_result = sh_in >> sh_shift[3:0];
      4'b1011: sh_result = 16'($signed(sh_in) >>> sh_shift[3:0]);
      default: sh_result = sh_in;
    endcase
  end

  // Reference: shift a wide copy by the full amount, read the result window and the bit just outside it
  function automatic logic [19:0] ref_op(input logic [3:0] f, input logic [4:0] n, input logic [15:0] x);
    logic [63:0] w;
    logic [15:0] r;
    logic        c;
    int          s;
    s = int'(n);
    if (f[3:2] != 2'b10) return {x, x[15], (x == 16'h0), 1'b0, 1'b1};
    case (f[1:0])
      2'b00: begin w = {48'b0, x} << s; r = w[15:0]; c = w[16]; end
      2'b01: begin
        w = {32'b0, x, x} << (s % 16); r = w[31:16];
        c = ((s % 16) != 0) ? r[0] : 1'b0;
      end
      2'b10: begin w = {32'b0, x, 16'b0} >> s; r = w[31:16]; c = w[15]; end
      default: begin
        w = {{32{x[15]}}, x, 16'b0};
        w = 64'($signed(w) >>> s); r = w[31:16]; c = w[15];
      end
    endcase
    return {r, r[15], (r == 16'h0), c, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit id, input logic v, input logic [3:0] f, input logic [4:0] n,
                           input logic [15:0] x);
    if (id == 1'b0) begin req0 = v; fcode0 = f; shamt0 = n; data0 = x; end
    else            begin req1 = v; fcode1 = f; shamt1 = n; data1 = x; end
  endtask

  // Called at a negedge with the DUT idle; checks the full 3-cycle handshake
  task automatic run_op(input bit id, input logic [3:0] f, input logic [4:0] n, input logic [15:0] x,
                        input logic [15:0] er, input logic [3:0] ec, input string tag);
    drive_req(id, 1'b1, f, n, x);
    @(posedge clk); @(negedge clk);
    chk({tag, " busy@drive"}, 16'(busy), 16'd1);
    chk({tag, " done@drive"}, 16'({done1, done0}), 16'd0);
    chk({tag, " sh_shift"}, 16'(sh_shift), 16'({1'b0, n[3:0]}));
    chk({tag, " sh_in"}, sh_in, x);
    // operands are latched at grant; disturbing them now must not matter
    drive_req(id, 1'b1, 4'($urandom), 5'($urandom), 16'($urandom));
    @(posedge clk); @(negedge clk);
    chk({tag, " done"}, 16'({done1, done0}), id ? 16'd2 : 16'd1);
    chk({tag, " result"}, result, er);
    chk({tag, " code"}, 16'(code), 16'(ec));
    drive_req(id, 1'b0, 4'd0, 5'd0, 16'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, " idle"}, 16'({busy, done1, done0}), 16'd0);
  endtask

  typedef struct {
    bit          id;
    logic [3:0]  f;
    logic [4:0]  n;
    logic [15:0] x;
    logic [15:0] er;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [19:0] e;
    int          order[3];
    int          got;
    bit          seen;

    tbl[0]  = '{1'b0, 4'b1000, 5'd4,  16'h0001, 16'h0010, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1011, 5'd3,  16'h8000, 16'hF000, 4'b1000};
    tbl[2]  = '{1'b1, 4'b1010, 5'd1,  16'h0003, 16'h0001, 4'b0010};
    tbl[3]  = '{1'b0, 4'b1001, 5'd1,  16'h8001, 16'h0003, 4'b0010};
    tbl[4]  = '{1'b0, 4'b1010, 5'd20, 16'h1234, 16'h0000, 4'b0100};
    tbl[5]  = '{1'b1, 4'b0000, 5'd0,  16'h00FF, 16'h00FF, 4'b0001};
    tbl[6]  = '{1'b0, 4'b1011, 5'd16, 16'h8000, 16'hFFFF, 4'b1010};
    tbl[7]  = '{1'b1, 4'b1000, 5'd16, 16'h0001, 16'h0000, 4'b0110};
    tbl[8]  = '{1'b0, 4'b1001, 5'd17, 16'h8001, 16'h0003, 4'b0010};
    tbl[9]  = '{1'b1, 4'b1010, 5'd0,  16'h8000, 16'h8000, 4'b1000};
    tbl[10] = '{1'b0, 4'b1011, 5'd31, 16'h7FFF, 16'h0000, 4'b0100};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 5'd0, 16'd0);
    drive_req(1'b1, 1'b0, 4'd0, 5'd0, 16'd0);
    @(negedge clk); @(negedge clk);
    chk("reset done/busy", 16'({busy, done1, done0}), 16'd0);
    chk("reset result", result, 16'h0);
    chk("reset code", 16'(code), 16'h0);
    chk("reset sh_fcode", 16'(sh_fcode), 16'h8);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      run_op(tbl[i].id, tbl[i].f, tbl[i].n, tbl[i].x, tbl[i].er, tbl[i].ec, $sformatf("tbl%0d", i));

    // Both requesters held from reset: order of service
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    drive_req(1'b0, 1'b1, 4'b1000, 5'd1, 16'h0001);
    drive_req(1'b1, 1'b1, 4'b1010, 5'd1, 16'h0002);
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      if (done0 || done1) begin
        order[got] = done1 ? 1 : 0;
        got++;
        if (got == 3) begin
          drive_req(1'b0, 1'b0, 4'd0, 5'd0, 16'd0);
          drive_req(1'b1, 1'b0, 4'd0, 5'd0, 16'd0);
        end
      end
    end
    drive_req(1'b0, 1'b0, 4'd0, 5'd0, 16'd0);
    drive_req(1'b1, 1'b0, 4'd0, 5'd0, 16'd0);
    chk("arb done count", 16'(got), 16'd3);
    if (got == 3) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      chk("arb order0", 16'(order[0]), 16'd0);
      chk("arb order1", 16'(order[1]), 16'd0);
      chk("arb order2", 16'(order[2]), 16'd0);
`else
      chk("arb order0", 16'(order[0]), 16'd0);
      chk("arb order1", 16'(order[1]), 16'd1);
      chk("arb order2", 16'(order[2]), 16'd0);
`endif
    end
    @(negedge clk); @(negedge clk);

    // Load a nonzero result, then reset in the middle of the next op
    run_op(tbl[1].id, tbl[1].f, tbl[1].n, tbl[1].x, tbl[1].er, tbl[1].ec, "pre-rst");
    drive_req(1'b0, 1'b1, 4'b1000, 5'd2, 16'h0101);
    @(posedge clk); @(negedge clk);
    chk("mid-op busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst outputs", 16'({busy, done1, done0}), 16'd0);
    chk("rst result", result, 16'h0);
    chk("rst code", 16'(code), 16'h0);
    chk("rst sh_fcode", 16'(sh_fcode), 16'h8);
    chk("rst sh_in", sh_in, 16'h0);
    chk("rst sh_shift", 16'(sh_shift), 16'h0);
    drive_req(1'b0, 1'b0, 4'd0, 5'd0, 16'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    chk("no done after rst", 16'(seen), 16'd0);
    run_op(tbl[0].id, tbl[0].f, tbl[0].n, tbl[0].x, tbl[0].er, tbl[0].ec, "post-rst");

    for (int i = 0; i < 150; i++) begin
      bit          id;
      logic [3:0]  f;
      logic [4:0]  n;
      logic [15:0] x;
      id = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : {2'b10, 2'($urandom)};
      n  = 5'($urandom);
      x  = 16'($urandom);
      e  = ref_op(f, n, x);
      run_op(id, f, n, x, e[19:4], e[3:0], $sformatf("rnd%0d f=%h n=%0d x=%h", i, f, n, x));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end

endmodule
